io_mem_burst_dma: RTL and testbench



---
 rtl/io_mem_burst_dma.sv | 160 ++++++++++++++++
 tb/tb_io_mem_burst_dma.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_mem_burst_dma.sv
// rtl/io_mem_burst_dma.sv - burst DMA engine between a stream port and an Avalon-MM memory port
// Read mode streams memory into a FIFO feeding src; write mode streams snk into memory.
`timescale 1ns/1ps
module io_mem_burst_dma #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int MAX_BURST  = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_dir,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [LEN_W-1:0]    cmd_len,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   output logic [6:0]          avm_burstcount,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic [DATA_W-1:0]   snk_data,
   input  logic                snk_valid,
   output logic                snk_ready,
   output logic [DATA_W-1:0]   src_data,
   output logic                src_valid,
   input  logic                src_ready
);
   localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BURST, FIN} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]    remaining;
   logic [LEN_W-1:0]    rem_after;
   logic [6:0]          bc;
   logic [6:0]          beat_cnt;
   logic                done_q;
   logic                push, pop, wr_beat, burst_end;

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    fifo_cnt;
   logic [CNT_W-1:0]    free;

   function automatic logic [6:0] burst_size(input logic [LEN_W-1:0] rem);
      if (rem >= LEN_W'(MAX_BURST)) return 7'(MAX_BURST);
      return 7'(rem);
   endfunction

   assign free      = CNT_W'(FIFO_DEPTH) - fifo_cnt;
   assign push      = (state == RD_DATA) && (beat_cnt != 7'd0) && avm_readdatavalid;
   assign pop       = src_valid && src_ready;
   assign wr_beat   = (state == WR_BURST) && snk_valid && !avm_waitrequest;
   assign burst_end = (push || wr_beat) && (beat_cnt == 7'd1);
   assign rem_after = remaining - LEN_W'(bc);

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      avm_read  = 1'b0;
      avm_write = 1'b0;
      snk_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (cmd_len == '0)  state_nxt = FIN;
               else if (cmd_dir)   state_nxt = WR_BURST;
               else                state_nxt = RD_REQ;
            end
         end
         RD_REQ: begin
            // Only request once the whole burst is guaranteed room in the FIFO.
            avm_read = (32'(free) >= 32'(bc));
            if (avm_read && !avm_waitrequest) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            if (burst_end && (rem_after != '0))
               state_nxt = RD_REQ;
            else if ((beat_cnt == 7'd0) && (fifo_cnt == '0))
               state_nxt = FIN;
         end
         WR_BURST: begin
            avm_write = snk_valid;
            snk_ready = !avm_waitrequest;
            if (burst_end && (rem_after == '0)) state_nxt = FIN;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         bc        <= '0;
         beat_cnt  <= '0;
         done_q    <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_q <= (state == FIN);
         if ((state == IDLE) && cmd_valid) begin
            addr      <= cmd_addr;
            remaining <= cmd_len;
            bc        <= burst_size(cmd_len);
            beat_cnt  <= burst_size(cmd_len);
         end else if (burst_end) begin
            // A zero beat count after the final burst marks the read-drain phase.
            addr      <= addr + (ADDR_W'(bc) << BYTE_SHIFT);
            remaining <= rem_after;
            bc        <= burst_size(rem_after);
            beat_cnt  <= burst_size(rem_after);
         end else if (push || wr_beat) begin
            beat_cnt  <= beat_cnt - 7'd1;
         end
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) fifo_mem[wr_ptr] <= avm_readdata;
   end

   assign src_valid      = (fifo_cnt != '0);
   assign src_data       = fifo_mem[rd_ptr];
   assign busy           = (state != IDLE);
   assign done           = done_q;
   assign avm_address    = addr;
   assign avm_writedata  = snk_data;
   assign avm_byteenable = '1;
   assign avm_burstcount = (avm_read || avm_write) ? bc : 7'd0;
endmodule

// File: tb/tb_io_mem_burst_dma.sv
// tb/tb_io_mem_burst_dma.sv - self-checking bench for io_mem_burst_dma
// Bus/stream model with scoreboard queues plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_io_mem_burst_dma;
   localparam int DW = 64, AW = 32, LW = 16, MB = 8, FD = 16;

   logic clk_clk = 1'b0;
   logic reset_reset_n = 1'b0;
   logic cmd_valid, cmd_ready, cmd_dir;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_len;
   logic busy, done;
   logic [AW-1:0] avm_address;
   logic avm_read, avm_write;
   logic [DW-1:0] avm_writedata;
   logic [DW/8-1:0] avm_byteenable;
   logic [6:0] avm_burstcount;
   logic avm_waitrequest;
   logic [DW-1:0] avm_readdata;
   logic avm_readdatavalid;
   logic [DW-1:0] snk_data;
   logic snk_valid, snk_ready;
   logic [DW-1:0] src_data;
   logic src_valid, src_ready;

   always #5 clk_clk = ~clk_clk;

   io_mem_burst_dma #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
      .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready));

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   typedef struct {logic [31:0] addr; int bc;} burst_t;
   burst_t exp_b[$];
   burst_t obs_b[$];
   burst_t tmp_b;
   logic [31:0] rd_pend[$];
   logic [63:0] src_exp[$];
   logic [63:0] snk_q[$];
   logic [63:0] wmem [logic [31:0]];
   int buf_cnt = 0, wr_beat = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0, cyc = 0;
   int src_out = 0, last_wr_cyc = 0, bus_ops = 0, rdv_cnt = 0;
   bit wait_rand = 0, gap_rand = 0, src_rdy = 1, tog = 0;
   bit prev_hold = 0;
   logic [31:0] prev_addr;
   logic [6:0] prev_bc;

   function automatic logic [63:0] memval(input logic [31:0] a);
      return {a ^ 32'hC0DE_0000, a};
   endfunction

   // Burst plan from the command: chunks of at most MB words, address advancing by 8 bytes per word.
   task automatic plan(input logic [31:0] a, input int len);
      int rem;
      burst_t b;
      rem = len;
      while (rem > 0) begin
         b.addr = a;
         b.bc = (rem < MB) ? rem : MB;
         exp_b.push_back(b);
         a = a + 32'(b.bc * 8);
         rem = rem - b.bc;
      end
   endtask

   task automatic issue(input bit dir, input logic [31:0] a, input int len);
      plan(a, len);
      for (int i = 0; i < len; i++) begin
         if (!dir) src_exp.push_back(memval(a + 32'(i * 8)));
         else      snk_q.push_back(64'h1111_0000_0000_0000 + 64'(i));
      end
      done_cnt = 0; src_out = 0; bus_ops = 0; rdv_cnt = 0;
      obs_b.delete();
      @(negedge clk_clk);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = a; cmd_len = LW'(len);
      for (int t = 0; ; t++) begin
         #1;
         if (cmd_ready) break;
         if (t > 50) begin
            chk("cmd_accept_timeout", 64'(0), 64'(1));
            break;
         end
         @(negedge clk_clk);
      end
      @(negedge clk_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (done_cnt == 0 && t < budget) begin
         @(negedge clk_clk); #2;
         t++;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'(1));
      repeat (4) @(negedge clk_clk);
      #2;
      chk("single_done", 64'(done_cnt), 64'(1));
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_avm_read"}, 64'(avm_read), 64'(0));
      chk({tag, "_avm_write"}, 64'(avm_write), 64'(0));
      chk({tag, "_snk_ready"}, 64'(snk_ready), 64'(0));
      chk({tag, "_src_valid"}, 64'(src_valid), 64'(0));
      chk({tag, "_avm_address"}, 64'(avm_address), 64'(0));
      chk({tag, "_avm_burstcount"}, 64'(avm_burstcount), 64'(0));
   endtask

   // Avalon slave, stream endpoints and per-cycle scoreboard.
   initial begin
      avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
      snk_valid = 1'b0; snk_data = '0; src_ready = 1'b0;
      forever begin
         @(negedge clk_clk);
         cyc++;
         tog = !tog;
         avm_waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
         avm_readdatavalid = 1'b0;
         if (rd_pend.size() > 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = memval(rd_pend.pop_front());
         end
         snk_valid = tog && (snk_q.size() > 0);
         snk_data = (snk_q.size() > 0) ? snk_q[0] : '0;
         src_ready = src_rdy;
         #1;
         if (!reset_reset_n) begin
            rd_pend.delete(); src_exp.delete(); exp_b.delete(); snk_q.delete();
            buf_cnt = 0; wr_beat = 0; prev_hold = 0;
         end else begin
            chk("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            chk("byteenable", 64'(avm_byteenable), 64'hFF);
            chk("src_valid_vs_fifo", 64'(src_valid), 64'(buf_cnt > 0));
            if (!avm_read && !avm_write) chk("idle_burstcount", 64'(avm_burstcount), 64'(0));
            if (prev_hold) begin
               chk("hold_read", 64'(avm_read), 64'(1));
               chk("hold_addr", 64'(avm_address), 64'(prev_addr));
               chk("hold_bc", 64'(avm_burstcount), 64'(prev_bc));
            end
            prev_hold = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            prev_bc = avm_burstcount;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (avm_read && !avm_waitrequest) begin
               bus_ops++;
               chk("rd_reserve", 64'(int'(avm_burstcount) <= FD - buf_cnt), 64'(1));
               if (exp_b.size() == 0) chk("unexpected_read", 64'(1), 64'(0));
               else begin
                  chk("rd_addr", 64'(avm_address), 64'(exp_b[0].addr));
                  chk("rd_bc", 64'(avm_burstcount), 64'(exp_b[0].bc));
                  void'(exp_b.pop_front());
               end
               tmp_b.addr = avm_address;
               tmp_b.bc = int'(avm_burstcount);
               obs_b.push_back(tmp_b);
               for (int i = 0; i < int'(avm_burstcount); i++)
                  rd_pend.push_back(avm_address + 32'(i * 8));
            end
            if (snk_valid && snk_ready && !(avm_write && !avm_waitrequest))
               chk("snk_without_write", 64'(1), 64'(0));
            if (avm_write && !avm_waitrequest) begin
               bus_ops++;
               last_wr_cyc = cyc;
               chk("wr_snk_handshake", 64'(snk_valid && snk_ready), 64'(1));
               if (snk_q.size() > 0) begin
                  chk("wr_data", avm_writedata, snk_q[0]);
                  void'(snk_q.pop_front());
               end
               if (exp_b.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
               else begin
                  chk("wr_addr", 64'(avm_address), 64'(exp_b[0].addr));
                  chk("wr_bc", 64'(avm_burstcount), 64'(exp_b[0].bc));
                  if (wr_beat == 0) begin
                     tmp_b.addr = avm_address;
                     tmp_b.bc = int'(avm_burstcount);
                     obs_b.push_back(tmp_b);
                  end
                  wmem[avm_address + 32'(wr_beat * 8)] = avm_writedata;
                  wr_beat++;
                  if (wr_beat == exp_b[0].bc) begin
                     wr_beat = 0;
                     void'(exp_b.pop_front());
                  end
               end
            end
            if (src_valid && src_ready) begin
               if (src_exp.size() == 0) chk("unexpected_src", 64'(1), 64'(0));
               else chk("src_data", src_data, src_exp.pop_front());
               src_out++;
               buf_cnt--;
            end
            if (avm_readdatavalid) begin
               buf_cnt++;
               rdv_cnt++;
            end
            if (buf_cnt > FD) chk("fifo_overflow", 64'(buf_cnt), 64'(FD));
         end
      end
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int t;
      cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) @(negedge clk_clk);
      #2;
      reset_check("rst0");
      @(negedge clk_clk);
      reset_reset_n = 1'b1;

      // Read 20 words in three bursts.
      issue(1'b0, 32'h1000, 20);
      wait_done(500);
      chk("t1_nbursts", 64'(obs_b.size()), 64'(3));
      if (obs_b.size() == 3) begin
         chk("t1_b0_addr", 64'(obs_b[0].addr), 64'h1000);
         chk("t1_b0_bc", 64'(obs_b[0].bc), 64'(8));
         chk("t1_b1_addr", 64'(obs_b[1].addr), 64'h1040);
         chk("t1_b1_bc", 64'(obs_b[1].bc), 64'(8));
         chk("t1_b2_addr", 64'(obs_b[2].addr), 64'h1080);
         chk("t1_b2_bc", 64'(obs_b[2].bc), 64'(4));
      end
      chk("t1_words", 64'(src_out), 64'(20));
      chk("t1_left", 64'(src_exp.size()), 64'(0));

      // Write 5 words with gappy source and random waitrequest.
      wait_rand = 1;
      issue(1'b1, 32'h2000, 5);
      wait_done(500);
      wait_rand = 0;
      chk("t2_nbursts", 64'(obs_b.size()), 64'(1));
      if (obs_b.size() == 1) begin
         chk("t2_b0_addr", 64'(obs_b[0].addr), 64'h2000);
         chk("t2_b0_bc", 64'(obs_b[0].bc), 64'(5));
      end
      for (int i = 0; i < 5; i++)
         chk("t2_mem", wmem.exists(32'h2000 + 32'(i * 8)) ? wmem[32'h2000 + 32'(i * 8)] : 64'hDEAD,
             64'h1111_0000_0000_0000 + 64'(i));
      chk("t2_done_after_last_beat", 64'(done_cyc - last_wr_cyc), 64'(2));

      // Read 32 words with the consumer stalled for 100 cycles.
      gap_rand = 1;
      src_rdy = 0;
      issue(1'b0, 32'h5000, 32);
      repeat (100) @(negedge clk_clk);
      #2;
      chk("t3_buffered", 64'(buf_cnt), 64'(16));
      chk("t3_bursts_stalled", 64'(obs_b.size()), 64'(2));
      chk("t3_no_output", 64'(src_out), 64'(0));
      src_rdy = 1;
      wait_done(2000);
      gap_rand = 0;
      chk("t3_words", 64'(src_out), 64'(32));
      chk("t3_left", 64'(src_exp.size()), 64'(0));
      chk("t3_nbursts", 64'(obs_b.size()), 64'(4));

      // Zero-length command.
      issue(1'b0, 32'h6000, 0);
      wait_done(20);
      chk("t4_latency", 64'(done_cyc - acc_cyc), 64'(2));
      chk("t4_bus_ops", 64'(bus_ops), 64'(0));

      // Address wrap.
      issue(1'b0, 32'hFFFF_FFC0, 16);
      wait_done(500);
      chk("t5_nbursts", 64'(obs_b.size()), 64'(2));
      if (obs_b.size() == 2) begin
         chk("t5_b0_addr", 64'(obs_b[0].addr), 64'hFFFF_FFC0);
         chk("t5_b1_addr", 64'(obs_b[1].addr), 64'h0);
      end
      chk("t5_words", 64'(src_out), 64'(16));

      // Reset in the middle of a read, then a short read.
      issue(1'b0, 32'h3000, 24);
      t = 0;
      while (rdv_cnt < 3 && t < 100) begin
         @(negedge clk_clk); #2;
         t++;
      end
      chk("t6_data_started", 64'(rdv_cnt >= 3), 64'(1));
      @(negedge clk_clk);
      reset_reset_n = 1'b0;
      #2;
      reset_check("rst_mid");
      @(negedge clk_clk);
      #2;
      reset_check("rst_hold");
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      issue(1'b0, 32'h4000, 4);
      wait_done(200);
      chk("t6_words", 64'(src_out), 64'(4));
      chk("t6_left", 64'(src_exp.size()), 64'(0));
      chk("t6_nbursts", 64'(obs_b.size()), 64'(1));
      if (obs_b.size() == 1) begin
         chk("t6_b0_addr", 64'(obs_b[0].addr), 64'h4000);
         chk("t6_b0_bc", 64'(obs_b[0].bc), 64'(4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
